bcd_divider_seq: RTL and testbench

- Sequential inverse of the team's BCD digit multiplier.
- Takes an NDIG-digit BCD dividend and a single BCD-digit divisor.
- Produces an NDIG-digit BCD quotient and a one-digit BCD remainder.
- Datapath: BCD→binary on load, restoring binary division one bit per cycle, binary→BCD on completion. Uses a start/busy/done handshake, so the consumer sees a fixed latency.

---
 rtl/bcd_divider_seq.sv | 145 ++++++++++++++
 tb/tb_bcd_divider_seq.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/bcd_divider_seq.sv
// ============================================================================
// Module   : bcd_divider_seq
// Function : NDIG-digit BCD dividend / one BCD digit, restoring binary division
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module bcd_divider_seq #(
  parameter int NDIG = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [4*NDIG-1:0]   dividend_bcd,
  input  logic [3:0]          divisor_bcd,
  output logic [4*NDIG-1:0]   quotient_bcd,
  output logic [3:0]          remainder_bcd,
  output logic                busy,
  output logic                done,
  output logic                err
);

  localparam int BW = 3*NDIG + 1;
  localparam int CW = $clog2(BW);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    DIV  = 3'd2,
    PACK = 3'd3,
    FIN  = 3'd4
  } state_t;

  state_t               state;
  logic [4*NDIG-1:0]    dvd_bcd;
  logic [3:0]           dvs;
  logic [BW-1:0]        dvd;
  logic [3:0]           pr;
  logic [CW-1:0]        cnt;

  logic [4:0]           pr_shift;
  logic                 take;

  function automatic logic digits_ok(input logic [4*NDIG-1:0] b);
    logic ok;
    ok = 1'b1;
    for (int k = 0; k < NDIG; k++)
      if (b[4*k +: 4] > 4'd9) ok = 1'b0;
    return ok;
  endfunction

  function automatic logic [BW-1:0] bcd_to_bin(input logic [4*NDIG-1:0] b);
    logic [BW-1:0] acc;
    acc = '0;
    for (int k = NDIG-1; k >= 0; k--)
      acc = BW'(acc * 10) + BW'(b[4*k +: 4]);
    return acc;
  endfunction

  // Double-dabble: quotient never exceeds the dividend, so NDIG digits suffice.
  function automatic logic [4*NDIG-1:0] bin_to_bcd(input logic [BW-1:0] b);
    logic [4*NDIG-1:0] r;
    r = '0;
    for (int i = BW-1; i >= 0; i--) begin
      for (int d = 0; d < NDIG; d++)
        if (r[4*d +: 4] >= 4'd5) r[4*d +: 4] = r[4*d +: 4] + 4'd3;
      r = {r[4*NDIG-2:0], b[i]};
    end
    return r;
  endfunction

  // Partial remainder stays below the divisor, so the shifted value fits in 5 bits.
  assign pr_shift = {pr, dvd[BW-1]};
  assign take     = (pr_shift >= {1'b0, dvs});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      dvd_bcd       <= '0;
      dvs           <= '0;
      dvd           <= '0;
      pr            <= '0;
      cnt           <= '0;
      quotient_bcd  <= '0;
      remainder_bcd <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      err           <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            dvd_bcd <= dividend_bcd;
            dvs     <= divisor_bcd;
            err     <= 1'b0;
            busy    <= 1'b1;
            state   <= LOAD;
          end
        end
        LOAD: begin
          if (!digits_ok(dvd_bcd) || dvs > 4'd9 || dvs == 4'd0) begin
            err           <= 1'b1;
            quotient_bcd  <= '0;
            remainder_bcd <= '0;
            busy          <= 1'b0;
            done          <= 1'b1;
            state         <= FIN;
          end else begin
            dvd   <= bcd_to_bin(dvd_bcd);
            pr    <= '0;
            cnt   <= CW'(BW-1);
            state <= DIV;
          end
        end
        DIV: begin
          // Dividend register doubles as the quotient: MSB out, quotient bit in.
          dvd <= {dvd[BW-2:0], take};
          pr  <= take ? 4'(pr_shift - {1'b0, dvs}) : pr_shift[3:0];
          cnt <= cnt - 1'b1;
          if (cnt == '0) state <= PACK;
        end
        PACK: begin
          quotient_bcd  <= bin_to_bcd(dvd);
          remainder_bcd <= pr;
          busy          <= 1'b0;
          done          <= 1'b1;
          state         <= FIN;
        end
        FIN: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_bcd_divider_seq.sv
// ============================================================================
// Module   : tb_bcd_divider_seq
// Function : directed and sweep checks of bcd_divider_seq with NDIG=2
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_bcd_divider_seq;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] dividend_bcd;
  logic [3:0] divisor_bcd;
  logic [7:0] quotient_bcd;
  logic [3:0] remainder_bcd;
  logic       busy;
  logic       done;
  logic       err;

  int errors = 0;
  int checks = 0;

  bcd_divider_seq #(.NDIG(2)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .dividend_bcd  (dividend_bcd),
    .divisor_bcd   (divisor_bcd),
    .quotient_bcd  (quotient_bcd),
    .remainder_bcd (remainder_bcd),
    .busy          (busy),
    .done          (done),
    .err           (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One request; lat = edges after the start edge until done is seen.
  task automatic run(input logic [7:0] dvd, input logic [3:0] dv,
                     input logic [7:0] eq, input logic [3:0] er,
                     input logic ee, input int lat);
    int n;
    int nbusy;
    @(negedge clk);
    dividend_bcd = dvd;
    divisor_bcd  = dv;
    start        = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("err_clr_on_start", err, 0);
    n     = 0;
    nbusy = busy ? 1 : 0;
    while (n < 40) begin
      @(posedge clk);
      #1;
      n++;
      if (done) break;
      if (busy) nbusy++;
    end
    check("latency", n, lat);
    check("busy_cycles", nbusy, lat);
    check("quotient", quotient_bcd, eq);
    check("remainder", remainder_bcd, er);
    check("err", err, ee);
    @(posedge clk);
    #1;
    check("done_one_cycle", done, 0);
  endtask

  initial begin
    int dcount;
    logic [7:0] qcap;
    logic [3:0] rcap;
    rst_n        = 1'b0;
    start        = 1'b0;
    dividend_bcd = '0;
    divisor_bcd  = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_q", quotient_bcd, 0);
    check("rst_r", remainder_bcd, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    @(negedge clk);
    rst_n = 1'b1;

    run(8'h99, 4'h9, 8'h11, 4'h0, 1'b0, 9);
    run(8'h47, 4'h5, 8'h09, 4'h2, 1'b0, 9);
    run(8'h00, 4'h7, 8'h00, 4'h0, 1'b0, 9);
    run(8'h35, 4'h0, 8'h00, 4'h0, 1'b1, 1);
    run(8'h3A, 4'h4, 8'h00, 4'h0, 1'b1, 1);
    run(8'h64, 4'hB, 8'h00, 4'h0, 1'b1, 1);
    run(8'h64, 4'h3, 8'h21, 4'h1, 1'b0, 9);

    // Operands and start disturbed mid-division must not affect the result.
    @(negedge clk);
    dividend_bcd = 8'h96;
    divisor_bcd  = 4'h8;
    start        = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    dividend_bcd = 8'h55;
    divisor_bcd  = 4'h2;
    start        = 1'b1;
    @(posedge clk);
    #1;
    start  = 1'b0;
    dcount = 0;
    qcap   = '0;
    rcap   = '0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (done) begin
        dcount++;
        qcap = quotient_bcd;
        rcap = remainder_bcd;
      end
    end
    check("middiv_done_count", dcount, 1);
    check("middiv_quotient", qcap, 8'h12);
    check("middiv_remainder", rcap, 4'h0);

    for (int d = 0; d < 100; d++) begin
      for (int v = 1; v < 10; v++) begin
        logic [7:0] eq;
        logic [3:0] er;
        eq = {4'((d / v) / 10), 4'((d / v) % 10)};
        er = 4'(d % v);
        run({4'(d / 10), 4'(d % 10)}, 4'(v), eq, er, 1'b0, 9);
        check("q_hi_digit_ok", quotient_bcd[7:4] <= 4'd9, 1);
        check("q_lo_digit_ok", quotient_bcd[3:0] <= 4'd9, 1);
      end
    end

    // Reset in the middle of DIV aborts immediately with no done pulse.
    @(negedge clk);
    dividend_bcd = 8'h47;
    divisor_bcd  = 4'h5;
    start        = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("arst_q", quotient_bcd, 0);
    check("arst_r", remainder_bcd, 0);
    check("arst_busy", busy, 0);
    check("arst_done", done, 0);
    check("arst_err", err, 0);
    dcount = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      if (done) dcount++;
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      if (done) dcount++;
    end
    check("arst_no_done", dcount, 0);
    run(8'h81, 4'h9, 8'h09, 4'h0, 1'b0, 9);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
